// File: rtl/mcs_io_master.sv
// MCS IO-bus master: one command at a time, strobe, wait for io_ready, respond.
// Optional WAIT timeout is built when MCS_IO_MASTER_TIMEOUT_EN is defined.
module mcs_io_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_address,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  logic   wr_q;

`ifdef MCS_IO_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        expire;
  logic        err_q;

  // saturate rather than wrap
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign expire  = (cnt_inc >= TMO);
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cmd_ready       <= 1'b1;
      wr_q            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      io_addr_strobe  <= 1'b0;
      io_read_strobe  <= 1'b0;
      io_write_strobe <= 1'b0;
      io_byte_enable  <= '0;
      io_address      <= '0;
      io_write_data   <= '0;
`ifdef MCS_IO_MASTER_TIMEOUT_EN
      cnt             <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            state           <= STROBE;
            cmd_ready       <= 1'b0;
            wr_q            <= cmd_wr;
            io_address      <= cmd_addr;
            io_write_data   <= cmd_wdata;
            io_byte_enable  <= cmd_be;
            io_addr_strobe  <= 1'b1;
            io_write_strobe <= cmd_wr;
            io_read_strobe  <= ~cmd_wr;
`ifdef MCS_IO_MASTER_TIMEOUT_EN
            cnt             <= '0;
`endif
          end
        end
        STROBE: begin
          io_addr_strobe  <= 1'b0;
          io_write_strobe <= 1'b0;
          io_read_strobe  <= 1'b0;
          if (io_ready) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= wr_q ? 32'h0 : io_read_data;
`ifdef MCS_IO_MASTER_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // io_ready has priority over an expiring counter
          if (io_ready) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= wr_q ? 32'h0 : io_read_data;
`ifdef MCS_IO_MASTER_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
`ifdef MCS_IO_MASTER_TIMEOUT_EN
          else begin
            cnt <= cnt_inc;
            if (expire) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              err_q     <= 1'b1;
            end
          end
`endif
        end
        RESP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs_io_master.sv
// Scoreboard bench for mcs_io_master: stimulus pushes expected responses,
// a negedge monitor pops and checks them against rsp_valid.
module tb_mcs_io_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data = '0;
  logic        io_ready = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  mcs_io_master #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_be(cmd_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .io_addr_strobe(io_addr_strobe),
    .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe),
    .io_byte_enable(io_byte_enable),
    .io_address(io_address),
    .io_write_data(io_write_data),
    .io_read_data(io_read_data),
    .io_ready(io_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // response monitor
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp act=1 exp=0 t=%0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // called at a negedge; returns at a negedge with cmd_ready high
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic chk_strobe(input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
    chk("addr_strobe", 32'(io_addr_strobe), 32'd1);
    chk("wr_strobe", 32'(io_write_strobe), 32'(wr));
    chk("rd_strobe", 32'(io_read_strobe), 32'(!wr));
    chk("io_address", io_address, a);
    chk("io_wdata", io_write_data, wd);
    chk("io_be", 32'(io_byte_enable), 32'(be));
    chk("ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  // d = cycles after the strobe cycle at which the responder raises io_ready
  task automatic txn(input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int d, input logic [31:0] rd);
    int   w;
    bit   to;
    exp_t e;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_wr = wr;
    cmd_addr = a;
    cmd_wdata = wd;
    cmd_be = be;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = $urandom;
    to = 1'b0;
    w = d;
`ifdef MCS_IO_MASTER_TIMEOUT_EN
    if (d > TMO) begin
      to = 1'b1;
      w = TMO;
    end
`endif
    e.rdata = (wr || to) ? 32'h0 : rd;
    e.err = to;
    e.cyc = cyc + 1 + w;
    sb.push_back(e);
    chk_strobe(wr, a, wd, be);
    for (int k = 0; k <= w; k++) begin
      if (k > 0) begin
        @(negedge clk);
        io_ready = 1'b0;
        chk("wait_strobe", 32'(io_addr_strobe | io_read_strobe
                              | io_write_strobe), 32'd0);
        chk("wait_addr", io_address, a);
      end
      if (k == d) begin
        io_ready = 1'b1;
        io_read_data = rd;
      end else begin
        io_read_data = $urandom;
      end
    end
    @(negedge clk);
    io_ready = 1'b0;
    @(negedge clk);
    chk("ready_back", 32'(cmd_ready), 32'd1);
    chk("idle_addr_hold", io_address, a);
    chk("rdata_hold", rsp_rdata, e.rdata);
    chk("err_hold", 32'(rsp_err), 32'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_strobe", 32'(io_addr_strobe), 32'd0);
    chk("rst_addr", io_address, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;

    txn(1'b1, 32'hC000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
    txn(1'b0, 32'hC000_0040, 32'h0, 4'hF, 3, 32'h1234_5678);
    txn(1'b0, 32'hC000_0044, 32'h0, 4'h3, TMO, 32'hA5A5_0001);
    txn(1'b0, 32'hC000_0048, 32'h0, 4'hF, TMO + 1, 32'h5A5A_0002);
    txn(1'b1, 32'hC000_004C, 32'h1111_2222, 4'h8, TMO + 2, 32'h0);

    // async reset while in WAIT
    wait_ready();
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_addr = 32'hC000_0080;
    cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_wait_strobe", 32'(io_addr_strobe), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_addr", io_address, 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_strobe", 32'(io_addr_strobe | io_read_strobe), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 32'hC000_0084, 32'h0, 4'hF, 1, 32'hCAFE_F00D);

    // io_ready in IDLE must do nothing
    io_ready = 1'b1;
    io_read_data = 32'hFFFF_0000;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ign_ready", 32'(cmd_ready), 32'd1);
      chk("idle_ign_strobe", 32'(io_addr_strobe), 32'd0);
    end
    io_ready = 1'b0;

    // back-to-back with cmd_valid held
    wait_ready();
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_addr = 32'hC000_0100;
    cmd_be = 4'hF;
    @(negedge clk);
    e.rdata = 32'h0BAD_0001;
    e.err = 1'b0;
    e.cyc = cyc + 1;
    sb.push_back(e);
    chk_strobe(1'b0, 32'hC000_0100, cmd_wdata, 4'hF);
    io_ready = 1'b1;
    io_read_data = 32'h0BAD_0001;
    cmd_wr = 1'b1;
    cmd_addr = 32'hC000_0104;
    cmd_wdata = 32'h7777_8888;
    cmd_be = 4'h1;
    @(negedge clk);
    chk("b2b_resp_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    io_ready = 1'b0;
    chk("b2b_ready_n3", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    e.rdata = 32'h0;
    e.cyc = cyc + 1;
    sb.push_back(e);
    chk_strobe(1'b1, 32'hC000_0104, 32'h7777_8888, 4'h1);
    io_ready = 1'b1;
    @(negedge clk);
    io_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      txn(1'($urandom), $urandom, $urandom, 4'($urandom),
          int'($urandom_range(0, 6)), $urandom);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
